// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 encodings and the read-master FSM state type shared by
// the read-channel logic and anything that decodes its signals.
package axi_pkg;

   // AR/AW burst type encodings
   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   // R/B response encodings (bit 1 set means an error class response)
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Read master transaction phases
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_state_t;

   // AxSIZE encoding for a beat of the given byte count (log2 of bytes)
   function automatic logic [2:0] axi_size(input int unsigned bytes);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if ((32'd1 << i) == bytes) s = 3'(i);
      end
      return s;
   endfunction

endpackage

// File: rtl/axi4_read_master.sv
// axi4_read_master: issues one AXI4 INCR read (cache-line burst or single
// beat) per request and streams each received beat out as a registered
// write strobe with its word offset inside the block.
// Optional feature macro: AXI_RRESP_CHECK_EN -- when defined, any beat with
// an error-class RRESP sets the sticky o_bus_error flag; otherwise RRESP is
// ignored and o_bus_error is tied low.
module axi4_read_master
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_WORDS = 16
) (
   input  logic                           clk,
   input  logic                           arst,
   input  logic                           i_start_read,
   input  logic                           i_single,
   input  logic [ADDR_WIDTH-1:0]          i_addr,
   output logic                           o_ar_valid,
   input  logic                           i_ar_ready,
   output logic [ADDR_WIDTH-1:0]          o_ar_addr,
   output logic [7:0]                     o_ar_len,
   output logic [2:0]                     o_ar_size,
   output logic [1:0]                     o_ar_burst,
   input  logic                           i_r_valid,
   output logic                           o_r_ready,
   input  logic [DATA_WIDTH-1:0]          i_r_data,
   input  logic                           i_r_last,
   input  logic [1:0]                     i_r_resp,
   output logic [DATA_WIDTH-1:0]          o_data,
   output logic                           o_data_we,
   output logic [$clog2(BLOCK_WORDS)-1:0] o_word_idx,
   output logic                           o_read_last,
   output logic                           o_busy,
   output logic                           o_bus_error
);

   localparam int IDX_W       = $clog2(BLOCK_WORDS);
   localparam int BEAT_BYTES  = DATA_WIDTH / 8;
   localparam int BLOCK_BYTES = BLOCK_WORDS * BEAT_BYTES;
   localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ~ADDR_WIDTH'(BLOCK_BYTES - 1);
   localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);
   localparam logic [7:0]            BURST_LEN = 8'(BLOCK_WORDS - 1);
   localparam logic [2:0]            AR_SIZE   = axi_size(BEAT_BYTES);

   rd_state_t              r_state;
   rd_state_t              w_state_next;
   logic [ADDR_WIDTH-1:0]  r_ar_addr;
   logic [7:0]             r_ar_len;
   logic [IDX_W-1:0]       r_beat_cnt;
   logic [DATA_WIDTH-1:0]  r_data;
   logic                   r_data_we;
   logic [IDX_W-1:0]       r_word_idx;
   logic                   r_read_last;

   logic                   w_ar_valid;
   logic                   w_r_ready;
   logic                   w_busy;
   logic                   w_start_acc;
   logic                   w_beat;
   logic                   w_final_beat;
   logic                   w_unused_resp;

   // A request is only taken when no transaction is outstanding
   assign w_start_acc  = (r_state == ST_IDLE) && i_start_read;
   // R handshake: ready is asserted exactly while in the data phase
   assign w_beat       = (r_state == ST_DATA) && i_r_valid;
   // Burst ends on RLAST or once the beat count reaches the requested length
   assign w_final_beat = w_beat && (i_r_last || (8'(r_beat_cnt) == r_ar_len));

   // State register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) r_state <= ST_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      w_ar_valid   = 1'b0;
      w_r_ready    = 1'b0;
      w_busy       = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (i_start_read) w_state_next = ST_ADDR;
         end
         ST_ADDR: begin
            w_ar_valid = 1'b1;
            if (i_ar_ready) w_state_next = ST_DATA;
         end
         ST_DATA: begin
            w_r_ready = 1'b1;
            if (w_final_beat) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Request capture, beat counter and registered beat output
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_ar_addr   <= '0;
         r_ar_len    <= '0;
         r_beat_cnt  <= '0;
         r_data      <= '0;
         r_data_we   <= 1'b0;
         r_word_idx  <= '0;
         r_read_last <= 1'b0;
      end else begin
         r_data_we   <= 1'b0;
         r_read_last <= 1'b0;
         if (w_start_acc) begin
            r_ar_addr <= i_single ? (i_addr & BEAT_MASK) : (i_addr & BLK_MASK);
            r_ar_len  <= i_single ? 8'd0 : BURST_LEN;
         end
         if ((r_state == ST_ADDR) && i_ar_ready) begin
            r_beat_cnt <= '0;
         end
         if (w_beat) begin
            r_data      <= i_r_data;
            r_data_we   <= 1'b1;
            r_word_idx  <= r_beat_cnt;
            r_beat_cnt  <= r_beat_cnt + 1'b1;
            r_read_last <= w_final_beat;
         end
      end
   end

`ifdef AXI_RRESP_CHECK_EN
   logic r_bus_error;

   // Sticky error: set by any error-class beat, cleared when a new read is taken
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_bus_error <= 1'b0;
      end else if (w_start_acc) begin
         r_bus_error <= 1'b0;
      end else if (w_beat && ((i_r_resp == AXI_RESP_SLVERR) || (i_r_resp == AXI_RESP_DECERR))) begin
         r_bus_error <= 1'b1;
      end
   end

   assign o_bus_error = r_bus_error;
`else
   assign o_bus_error = 1'b0;
`endif

   assign w_unused_resp = ^i_r_resp;

   assign o_ar_valid  = w_ar_valid;
   assign o_ar_addr   = r_ar_addr;
   assign o_ar_len    = r_ar_len;
   assign o_ar_size   = AR_SIZE;
   assign o_ar_burst  = AXI_BURST_INCR;
   assign o_r_ready   = w_r_ready;
   assign o_data      = r_data;
   assign o_data_we   = r_data_we;
   assign o_word_idx  = r_word_idx;
   assign o_read_last = r_read_last;
   assign o_busy      = w_busy;

endmodule

// File: doc/axi4_read_master.md
AXI4_READ_MASTER -- requirements
Module: axi4_read_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte address width of AR channel.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, R-channel beat width.
REQ-003 SHALL have parameter BLOCK_WORDS, default 16, beats per cache-line burst (power of 2, 2..256).
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, rising edge;
 arst  in  1  asynchronous, active-high reset;
 i_start_read  in  1  one-cycle request pulse from control unit (cache refill or non-cacheable read);
 i_single  in  1  sampled with i_start_read: 1 = single-beat non-cacheable read, 0 = BLOCK_WORDS burst;
 i_addr  in  ADDR_WIDTH  start byte address, sampled with i_start_read;
 o_ar_valid/i_ar_ready  out/in  1  AR handshake;
 o_ar_addr  out  ADDR_WIDTH  burst start address;
 o_ar_len  out  8  beats minus one;
 o_ar_size  out  3  log2(DATA_WIDTH/8);
 o_ar_burst  out  2  INCR (2'b01);
 i_r_valid/o_r_ready  in/out  1  R handshake;
 i_r_data  in  DATA_WIDTH  beat data;
 i_r_last  in  1  final beat marker;
 i_r_resp  in  2  beat response;
 o_data  out  DATA_WIDTH  registered beat data to cache/NC register;
 o_data_we  out  1  one-cycle strobe, o_data valid;
 o_word_idx  out  log2(BLOCK_WORDS)  word offset of o_data in block;
 o_read_last  out  1  one-cycle done pulse, drives control unit read-last input;
 o_busy  out  1  transaction in progress;
 o_bus_error  out  1  sticky error flag (see Configuration).

Function
REQ-005 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-006 IDLE: i_start_read=1 SHALL latch i_addr and i_single, go to ADDR next cycle; o_busy=1 from that cycle.
REQ-007 ADDR: o_ar_valid=1, address/len stable until i_ar_ready; on handshake go to DATA; o_ar_valid SHALL not drop before handshake.
REQ-008 Burst o_ar_addr SHALL be i_addr aligned down to block size; single o_ar_addr SHALL be i_addr aligned down to beat size; o_ar_len = BLOCK_WORDS-1 or 0.
REQ-009 DATA: o_r_ready=1; each i_r_valid&o_r_ready beat SHALL register i_r_data to o_data and assert o_data_we and o_word_idx (beat counter, reset to 0 on entry) the following cycle.
REQ-010 Beat counter SHALL increment per beat and wrap modulo BLOCK_WORDS.
REQ-011 Final beat = i_r_last or counter==o_ar_len; SHALL assert o_read_last in same cycle as its o_data_we and return to IDLE; o_busy deasserts with o_read_last.
REQ-012 i_r_last arriving early SHALL end the burst (o_read_last asserted); extra beats after o_ar_len without i_r_last SHALL not be accepted (o_r_ready=0 in IDLE).
REQ-013 i_start_read while o_busy=1 SHALL be ignored; start coincident with o_read_last SHALL be accepted (back-to-back).
REQ-014 Latency: minimum start-to-o_read_last = 2 + beats cycles with zero-wait slave.

Reset
REQ-015 arst SHALL force IDLE, counter 0, all outputs 0 (o_ar_burst constant 2'b01, o_ar_size constant) asynchronously, including mid-burst; no resumption after release.

Configuration
REQ-016 With AXI_RRESP_CHECK_EN defined, any beat with i_r_resp[1]=1 SHALL set o_bus_error (sticky until next accepted i_start_read); burst still completes normally.
REQ-017 Without AXI_RRESP_CHECK_EN, i_r_resp SHALL be ignored and o_bus_error tied 0.

Structure
REQ-018 AXI burst/size/resp encodings and FSM state enum SHALL reside in shared package axi_pkg.
REQ-019 Single flat module; no sub-module required.

Verification
REQ-020 Burst, addr 0x1034, ready slave, 16 beats 0..15 -> o_ar_addr 0x1000, len 15, 16 o_data_we with idx 0..15, o_read_last on 16th.
REQ-021 Single, addr 0x2006 -> o_ar_addr 0x2004, len 0, one o_data_we idx 0 with o_read_last.
REQ-022 i_ar_ready held low 5 cycles, random r_valid gaps -> o_ar_valid stable, data order intact, no lost/dup beats.
REQ-023 arst at beat 7 -> all outputs 0 next edge, new start then completes full 16-beat burst.
REQ-024 With AXI_RRESP_CHECK_EN, beat 3 resp 2'b10 -> o_bus_error=1 through o_read_last, cleared by next start.
REQ-025 i_start_read mid-burst ignored; start on o_read_last cycle -> second AR issued next cycle.
